fetch_stage: RTL and testbench

LC-3b instruction fetch stage. It owns the PC and runs the instruction-memory read handshake, then loads the IF/ID pipeline register that feeds the decode stage. It holds a one-entry skid buffer, so a response that arrives while decode is stalled is not lost. Branch redirects from downstream kill wrong-path fetches, including a request still in flight.

---
 rtl/lc3b_types.sv | 28 ++
 rtl/if_id_reg.sv | 27 ++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: the 16-bit word, the fetch FSM state encoding,
// the IF/ID pipeline register layout and PC arithmetic.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // BR with nzp=000: never taken, so it is safe to present as a bubble.
  localparam lc3b_word LC3B_NOP = 16'h0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_FULL,
    S_DROP
  } fetch_state_t;

  typedef struct packed {
    logic     valid;
    lc3b_word ir;
    lc3b_word pc;
  } if_id_t;

  // Word-aligned increment; wraps modulo 2^16.
  function automatic lc3b_word pc_inc(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Load wins over clear; clear turns the entry into a
// bubble while keeping its pc field.
module if_id_reg
  import lc3b_types::*;
#(
  parameter lc3b_word NOP_INSTR = LC3B_NOP
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{valid: 1'b0, ir: NOP_INSTR, pc: 16'h0000};
    end else if (load) begin
      q <= d;
    end else if (clear) begin
      q.valid <= 1'b0;
      q.ir    <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: PC, instruction-memory read handshake, one-entry skid
// buffer for stalled responses, and redirect handling that drops in-flight fetches.
module fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC  = 16'h0000,
  parameter lc3b_word NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_address,
  output logic        imem_read,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_id_valid,
  output logic [15:0] if_id_ir,
  output logic [15:0] if_id_pc
);

  fetch_state_t state, state_n;
  lc3b_word     pc, pc_n, addr_q, addr_n, pc_plus2;
  if_id_t       skid, skid_n;
  if_id_t       if_id_q, if_id_d;
  logic         if_id_load, if_id_clear, can_accept;

  assign pc_plus2   = pc_inc(pc);
  assign can_accept = !if_id_q.valid || !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_BOOT;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      skid   <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      addr_q <= addr_n;
      skid   <= skid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    addr_n     = addr_q;
    skid_n     = skid;
    if_id_load = 1'b0;
    if_id_d    = skid;
    if (redirect) begin
      pc_n   = redirect_pc;
      skid_n = '0;
      // An unanswered request must complete before the address may move.
      if ((state == S_REQ || state == S_DROP) && !imem_resp) begin
        state_n = S_DROP;
      end else begin
        addr_n  = redirect_pc;
        state_n = S_REQ;
      end
    end else begin
      case (state)
        S_BOOT: state_n = S_REQ;
        S_REQ: begin
          if (imem_resp) begin
            pc_n = pc_plus2;
            if (can_accept) begin
              if_id_load = 1'b1;
              if_id_d    = '{valid: 1'b1, ir: imem_rdata, pc: pc_plus2};
              addr_n     = pc_plus2;
            end else begin
              skid_n  = '{valid: 1'b1, ir: imem_rdata, pc: pc_plus2};
              state_n = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stall) begin
            if_id_load   = 1'b1;
            if_id_d      = skid;
            skid_n.valid = 1'b0;
            addr_n       = pc;
            state_n      = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp) begin
            addr_n  = pc;
            state_n = S_REQ;
          end
        end
        default: state_n = S_BOOT;
      endcase
    end
  end

  always_comb begin
    imem_read = (state == S_REQ) || (state == S_DROP);
  end

  assign if_id_clear  = redirect || !stall;
  assign imem_address = addr_q;
  assign if_id_valid  = if_id_q.valid;
  assign if_id_ir     = if_id_q.ir;
  assign if_id_pc     = if_id_q.pc;

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (if_id_load),
    .clear (if_id_clear),
    .d     (if_id_d),
    .q     (if_id_q)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural instruction memory with programmable
// latency, a scoreboard of fetched words, and directed checks on the handshake.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_address;
  logic        imem_read;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_id_valid;
  logic [15:0] if_id_ir;
  logic [15:0] if_id_pc;

  int unsigned total_checks  = 0;
  int unsigned passed_checks = 0;
  int unsigned latency       = 1;
  int unsigned mem_cnt       = 0;
  logic        drop_pending  = 1'b0;
  logic [31:0] sb_q[$];

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_valid  (if_id_valid),
    .if_id_ir     (if_id_ir),
    .if_id_pc     (if_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) passed_checks++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!if_id_valid && n < 20) begin
      tick();
      n++;
    end
    if (!if_id_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Memory: answers a held read after `latency` cycles, drives resp at edge+1.
  initial begin
    imem_resp  = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      imem_resp = 1'b0;
      if (!rst_n) begin
        mem_cnt = 0;
      end else if (imem_read) begin
        if (mem_cnt + 1 >= latency) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_word(imem_address);
          mem_cnt    = 0;
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Scoreboard: consume IF/ID when decode takes it, then log this cycle's response.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        drop_pending = 1'b0;
      end else if (redirect) begin
        sb_q.delete();
        if (imem_resp) drop_pending = 1'b0;
        if (imem_read && !imem_resp) drop_pending = 1'b1;
      end else begin
        if (if_id_valid && !stall) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_pc", {16'h0, if_id_pc}, 32'hFFFF_FFFF);
          end else begin
            logic [31:0] e;
            e = sb_q.pop_front();
            check("sb_ir", {16'h0, if_id_ir}, {16'h0, e[31:16]});
            check("sb_pc", {16'h0, if_id_pc}, {16'h0, e[15:0]});
          end
        end
        if (imem_resp) begin
          if (drop_pending) drop_pending = 1'b0;
          else sb_q.push_back({mem_word(imem_address), imem_address + 16'd2});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    latency     = 1;
    tick();
    tick();
    check("rst_read",  {31'h0, imem_read},   32'd0);
    check("rst_addr",  {16'h0, imem_address}, 32'h0000);
    check("rst_valid", {31'h0, if_id_valid}, 32'd0);
    check("rst_ir",    {16'h0, if_id_ir},    32'h0000);
    check("rst_pc",    {16'h0, if_id_pc},    32'h0000);
    #4;
    rst_n = 1'b1;
    #1;
    check("boot_read0", {31'h0, imem_read}, 32'd0);

    // Back-to-back single-cycle fetches from RESET_PC.
    tick();
    check("t1_read", {31'h0, imem_read}, 32'd1);
    check("t1_addr0", {16'h0, imem_address}, 32'h0000);
    tick();
    check("t1_addr1", {16'h0, imem_address}, 32'h0002);
    check("t1_pc1",   {16'h0, if_id_pc},     32'h0002);
    check("t1_ir1",   {16'h0, if_id_ir},     {16'h0, mem_word(16'h0000)});
    check("t1_valid", {31'h0, if_id_valid},  32'd1);
    tick();
    check("t1_addr2", {16'h0, imem_address}, 32'h0004);
    check("t1_pc2",   {16'h0, if_id_pc},     32'h0004);

    // Stall while the response for 0004 lands: goes to the skid buffer.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_read_full", {31'h0, imem_read}, 32'd0);
      check("t2_hold_pc",   {16'h0, if_id_pc},  32'h0004);
      check("t2_hold_vld",  {31'h0, if_id_valid}, 32'd1);
    end
    stall   = 1'b0;
    latency = 3;
    tick();
    check("t2_skid_pc", {16'h0, if_id_pc},     32'h0006);
    check("t2_skid_ir", {16'h0, if_id_ir},     {16'h0, mem_word(16'h0004)});
    check("t2_addr",    {16'h0, imem_address}, 32'h0006);
    check("t2_read",    {31'h0, imem_read},    32'd1);

    // Redirect while 0006 is still outstanding.
    tick();
    check("t3_bubble", {31'h0, if_id_valid}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 16'h3000;
    tick();
    redirect = 1'b0;
    check("t3_addr_held", {16'h0, imem_address}, 32'h0006);
    check("t3_read_drop", {31'h0, imem_read},    32'd1);
    check("t3_valid0",    {31'h0, if_id_valid},  32'd0);
    tick();
    check("t3_addr_new", {16'h0, imem_address}, 32'h3000);
    check("t3_valid1",   {31'h0, if_id_valid},  32'd0);
    wait_valid("t3_wait");
    check("t3_pc", {16'h0, if_id_pc}, 32'h3002);
    check("t3_ir", {16'h0, if_id_ir}, {16'h0, mem_word(16'h3000)});

    // Redirect, response and stall all in one cycle.
    stall = 1'b1;
    n = 0;
    tick();
    while (!imem_resp && n < 20) begin
      tick();
      n++;
    end
    check("t4_resp_seen", {31'h0, imem_resp}, 32'd1);
    check("t4_held_vld",  {31'h0, if_id_valid}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h4000;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    check("t4_valid0", {31'h0, if_id_valid},  32'd0);
    check("t4_ir_nop", {16'h0, if_id_ir},     32'h0000);
    check("t4_addr",   {16'h0, imem_address}, 32'h4000);
    check("t4_read",   {31'h0, imem_read},    32'd1);

    // PC wrap from FFFE.
    latency = 1;
    wait_valid("t5_wait");
    check("t5_pc4002", {16'h0, if_id_pc}, 32'h4002);
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    check("t5_addr_fffe", {16'h0, imem_address}, 32'hFFFE);
    check("t5_valid0",    {31'h0, if_id_valid},  32'd0);
    tick();
    check("t5_wrap_pc",   {16'h0, if_id_pc},     32'h0000);
    check("t5_wrap_addr", {16'h0, imem_address}, 32'h0000);
    check("t5_wrap_ir",   {16'h0, if_id_ir},     {16'h0, mem_word(16'hFFFE)});

    // Asynchronous reset in the middle of a request.
    latency = 4;
    tick();
    #4;
    rst_n = 1'b0;
    #1;
    check("t6_read",  {31'h0, imem_read},    32'd0);
    check("t6_addr",  {16'h0, imem_address}, 32'h0000);
    check("t6_valid", {31'h0, if_id_valid},  32'd0);
    check("t6_ir",    {16'h0, if_id_ir},     32'h0000);
    check("t6_pc",    {16'h0, if_id_pc},     32'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_restart_read", {31'h0, imem_read},    32'd1);
    check("t6_restart_addr", {16'h0, imem_address}, 32'h0000);
    wait_valid("t6_wait");
    check("t6_restart_pc", {16'h0, if_id_pc}, 32'h0002);
    check("t6_restart_ir", {16'h0, if_id_ir}, {16'h0, mem_word(16'h0000)});

    for (int i = 0; i < 10; i++) tick();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
